// File: rtl/pswd_seq_ctrl.sv
// Password front-end: button debounce, switch gating, failure lockout.
// Optional feature macro: PSWD_TIMEOUT_EN (self-issued end after ENTRY_TO).
module pswd_seq_ctrl #(
  parameter int DEB_CYCLES  = 16,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000,
  parameter int ENTRY_TO    = 5000,
  parameter int RES_TO      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_n,
  input  logic       btn_end_n,
  input  logic [9:0] sw,
  input  logic       chk_done,
  input  logic       chk_pass,
  output logic       start_pulse,
  output logic       end_pulse,
  output logic [9:0] sw_out,
  output logic       locked,
  output logic [3:0] fail_cnt,
  output logic [1:0] seq_state
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int RW = $clog2(RES_TO + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_WAIT  = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  state_t state;

  // index 0 = start button, index 1 = end button (pressed = 1)
  logic [1:0]         raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         deb;
  logic [1:0]         press;
  logic [1:0][DW-1:0] deb_cnt;
  logic [RW-1:0]      res_cnt;
  logic [LW-1:0]      lock_cnt;
  logic [3:0]         fail_inc;
  logic               entry_expired;

  assign raw       = {~btn_end_n, ~btn_start_n};
  assign fail_inc  = fail_cnt + 4'd1;
  assign seq_state = state;

  // Synchronise both buttons and emit one press pulse per accepted press
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      press   <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          deb[i]     <= sync2[i];
          press[i]   <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

`ifdef PSWD_TIMEOUT_EN
  localparam int EW = $clog2(ENTRY_TO + 1);

  logic [EW-1:0] entry_cnt;

  // Count cycles spent in ENTRY; cleared whenever the FSM is elsewhere
  always_ff @(posedge clk) begin
    if (rst || state != S_ENTRY) begin
      entry_cnt <= '0;
    end else begin
      entry_cnt <= entry_cnt + EW'(1);
    end
  end

  assign entry_expired = (state == S_ENTRY) &&
                         (entry_cnt == EW'(ENTRY_TO - 1));
`else
  logic unused_entry_to;

  assign entry_expired   = 1'b0;
  assign unused_entry_to = ^ENTRY_TO;
`endif

  // Sequencer FSM with registered pulses, gating and lockout timer
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      start_pulse <= 1'b0;
      end_pulse   <= 1'b0;
      sw_out      <= '0;
      locked      <= 1'b0;
      fail_cnt    <= '0;
      res_cnt     <= '0;
      lock_cnt    <= '0;
    end else begin
      start_pulse <= 1'b0;
      end_pulse   <= 1'b0;
      sw_out      <= '0;
      unique case (state)
        S_IDLE: begin
          if (press[0]) begin
            start_pulse <= 1'b1;
            sw_out      <= sw;
            state       <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (press[1] || entry_expired) begin
            end_pulse <= 1'b1;
            res_cnt   <= '0;
            state     <= S_WAIT;
          end else begin
            sw_out <= sw;
          end
        end
        S_WAIT: begin
          if (chk_done && chk_pass) begin
            fail_cnt <= '0;
            state    <= S_IDLE;
          end else if (chk_done ||
                       res_cnt == RW'(RES_TO - 1)) begin
            if (fail_inc >= 4'(MAX_FAIL)) begin
              fail_cnt <= 4'(MAX_FAIL);
              locked   <= 1'b1;
              lock_cnt <= LW'(LOCK_CYCLES - 1);
              state    <= S_LOCK;
            end else begin
              fail_cnt <= fail_inc;
              state    <= S_IDLE;
            end
          end else begin
            res_cnt <= res_cnt + RW'(1);
          end
        end
        S_LOCK: begin
          if (lock_cnt == '0) begin
            fail_cnt <= '0;
            locked   <= 1'b0;
            state    <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pswd_seq_ctrl.sv
// Bench for pswd_seq_ctrl: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural model.
module tb_pswd_seq_ctrl;

  localparam int DEB  = 4;
  localparam int MAXF = 3;
  localparam int LOCK = 20;
  localparam int ETO  = 50;
  localparam int RTO  = 8;
`ifdef PSWD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start_n;
  logic       btn_end_n;
  logic [9:0] sw;
  logic       chk_done;
  logic       chk_pass;
  logic       start_pulse;
  logic       end_pulse;
  logic [9:0] sw_out;
  logic       locked;
  logic [3:0] fail_cnt;
  logic [1:0] seq_state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pswd_seq_ctrl #(
    .DEB_CYCLES (DEB),
    .MAX_FAIL   (MAXF),
    .LOCK_CYCLES(LOCK),
    .ENTRY_TO   (ETO),
    .RES_TO     (RTO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start_n(btn_start_n),
    .btn_end_n  (btn_end_n),
    .sw         (sw),
    .chk_done   (chk_done),
    .chk_pass   (chk_pass),
    .start_pulse(start_pulse),
    .end_pulse  (end_pulse),
    .sw_out     (sw_out),
    .locked     (locked),
    .fail_cnt   (fail_cnt),
    .seq_state  (seq_state)
  );

  // behavioural model state (0 idle, 1 entry, 2 waiting verdict, 3 lockout)
  int         m_state  = 0;
  bit         m_start  = 1'b0;
  bit         m_end    = 1'b0;
  logic [9:0] m_sw     = '0;
  bit         m_locked = 1'b0;
  int         m_fail   = 0;
  int         ent_n    = 0;
  int         wait_n   = 0;
  int         lock_left = 0;
  logic [1:0] pe     = '0;
  logic [1:0] acc    = '0;
  logic [1:0] prev_s = '0;
  logic [1:0] syn_l;
  logic [1:0] np_l;
  int         run_n [2];
  logic [1:0] hist [$];

  logic [18:0] got_v;
  logic [18:0] exp_v;

  assign got_v = {start_pulse, end_pulse, sw_out, locked,
                  fail_cnt, seq_state};
  assign exp_v = {m_start, m_end, m_sw, m_locked,
                  4'(m_fail), 2'(m_state)};

  initial begin : ref_model
    run_n[0] = 0;
    run_n[1] = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_state = 0; m_start = 0; m_end = 0; m_sw = '0;
        m_locked = 0; m_fail = 0;
        pe = '0; acc = '0; prev_s = '0;
        run_n[0] = 0; run_n[1] = 0;
        hist.delete();
      end else begin
        m_start = 0; m_end = 0; m_sw = '0;
        case (m_state)
          0: if (pe[0]) begin
               m_start = 1; m_state = 1; m_sw = sw; ent_n = 0;
             end
          1: begin
               ent_n++;
               if (pe[1] || (TO_EN && ent_n == ETO)) begin
                 m_end = 1; m_state = 2; wait_n = 0;
               end else begin
                 m_sw = sw;
               end
             end
          2: begin
               wait_n++;
               if (chk_done && chk_pass) begin
                 m_fail = 0; m_state = 0;
               end else if (chk_done || wait_n == RTO) begin
                 m_fail = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
                 if (m_fail == MAXF) begin
                   m_state = 3; m_locked = 1; lock_left = LOCK;
                 end else begin
                   m_state = 0;
                 end
               end
             end
          default: begin
               lock_left--;
               if (lock_left == 0) begin
                 m_fail = 0; m_locked = 0; m_state = 0;
               end
             end
        endcase
        // level seen after the two-stage synchroniser
        hist.push_back({~btn_end_n, ~btn_start_n});
        if (hist.size() > 3) void'(hist.pop_front());
        syn_l = (hist.size() == 3) ? hist[0] : 2'b00;
        np_l = 2'b00;
        for (int b = 0; b < 2; b++) begin
          if (syn_l[b] == prev_s[b]) run_n[b]++;
          else run_n[b] = 1;
          prev_s[b] = syn_l[b];
          if (run_n[b] == DEB && syn_l[b] != acc[b]) begin
            acc[b]  = syn_l[b];
            np_l[b] = syn_l[b];
          end
        end
        pe = np_l;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    btn_start_n = 1'($urandom);
    btn_end_n = 1'($urandom);
    sw = 10'($urandom);
    chk_done = 1'($urandom);
    chk_pass = 1'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if (got_v !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc %0d got %h exp 0", c, got_v);
      end
    end
    rst = 1'b0;
    btn_start_n = 1'b1;
    btn_end_n = 1'b1;
    sw = '0;
    chk_done = 1'b0;
    chk_pass = 1'b0;
  endtask

  task automatic test_start_press();
    int pulses = 0;
    int at = -1;
    test_reset();
    for (int c = 0; c < 30; c++) begin
      btn_start_n = !(c < 10);
      @(posedge clk); #1;
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL start_model cyc %0d got %h exp %h", c, got_v, exp_v);
      end
      if (start_pulse) begin
        pulses++;
        if (at < 0) at = c + 1;
      end
    end
    n_chk++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL start_count got %0d exp 1", pulses);
    end
    n_chk++;
    if (at != 2 + DEB + 1) begin
      n_fail++;
      $display("FAIL start_latency got %0d exp %0d", at, 2 + DEB + 1);
    end
    n_chk++;
    if (seq_state !== 2'd1) begin
      n_fail++;
      $display("FAIL start_state got %0d exp 1", seq_state);
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int at = -1;
    test_reset();
    for (int c = 0; c < 40; c++) begin
      btn_start_n = (c < 12) ? ((c / 2) % 2 == 1) : (c >= 30);
      @(posedge clk); #1;
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL bounce_model cyc %0d got %h exp %h", c, got_v, exp_v);
      end
      if (start_pulse) begin
        pulses++;
        if (at < 0) at = c + 1;
      end
    end
    n_chk++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL bounce_count got %0d exp 1", pulses);
    end
    n_chk++;
    if (at != 19) begin
      n_fail++;
      $display("FAIL bounce_latency got %0d exp 19", at);
    end
  endtask

  task automatic test_pass_round();
    int ends = 0;
    bit seen = 1'b0;
    bit sd = 1'b0;
    test_reset();
    for (int c = 0; c < 50; c++) begin
      btn_start_n = !(c < 6);
      btn_end_n = !(c >= 20 && c < 26);
      sw = (c < 15) ? 10'h001 : 10'($urandom);
      chk_done = sd;
      chk_pass = 1'b1;
      sd = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL pass_model cyc %0d got %h exp %h", c, got_v, exp_v);
      end
      if (end_pulse) begin
        ends++;
        sd = 1'b1;
      end
      if (seq_state == 2'd1 && sw_out == 10'h001) seen = 1'b1;
    end
    chk_done = 1'b0;
    n_chk++;
    if (ends != 1) begin
      n_fail++;
      $display("FAIL pass_end_count got %0d exp 1", ends);
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL pass_sw_gate got 0 exp 1");
    end
    n_chk++;
    if (fail_cnt !== 4'd0 || seq_state !== 2'd0) begin
      n_fail++;
      $display("FAIL pass_final got fail %0d state %0d exp 0 0",
               fail_cnt, seq_state);
    end
  endtask

  task automatic test_lockout();
    int sp = 0;
    int lk = 0;
    logic [15:0] fs = '0;
    logic [3:0] pf = '0;
    bit sd = 1'b0;
    test_reset();
    for (int c = 0; c < 160; c++) begin
      int off = c % 45;
      int r = c / 45;
      btn_start_n = !((r < 3 && off < 6) || (c >= 118 && c < 124));
      btn_end_n = !(r < 3 && off >= 16 && off < 22);
      sw = 10'($urandom);
      chk_done = sd;
      chk_pass = 1'b0;
      sd = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL lock_model cyc %0d got %h exp %h", c, got_v, exp_v);
      end
      if (end_pulse) sd = 1'b1;
      if (locked) lk++;
      if (start_pulse) sp++;
      if (fail_cnt !== pf) begin
        fs = {fs[11:0], fail_cnt};
        pf = fail_cnt;
      end
    end
    chk_done = 1'b0;
    n_chk++;
    if (fs !== 16'h1230) begin
      n_fail++;
      $display("FAIL lock_fail_seq got %h exp 1230", fs);
    end
    n_chk++;
    if (lk != LOCK) begin
      n_fail++;
      $display("FAIL lock_cycles got %0d exp %0d", lk, LOCK);
    end
    n_chk++;
    if (sp != 3) begin
      n_fail++;
      $display("FAIL lock_start_count got %0d exp 3", sp);
    end
    n_chk++;
    if (locked !== 1'b0 || seq_state !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_final got locked %0d state %0d exp 0 0",
               locked, seq_state);
    end
  endtask

  task automatic test_timeout();
    int ep = 0;
    int nd = 0;
    logic [3:0] pf = '0;
    test_reset();
    for (int c = 0; c < 116; c++) begin
      int off = c % 40;
      int r = c / 40;
      rst = (c == 115);
      btn_start_n = !(r < 3 && off < 6);
      btn_end_n = !(r < 3 && off >= 12 && off < 18);
      chk_done = 1'b0;
      sw = 10'($urandom);
      @(posedge clk); #1;
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL tmo_model cyc %0d got %h exp %h", c, got_v, exp_v);
      end
      if (end_pulse) ep = c + 1;
      if (fail_cnt !== pf && c != 115) begin
        n_chk++;
        if (c + 1 - ep != RTO) begin
          n_fail++;
          $display("FAIL tmo_delay got %0d exp %0d", c + 1 - ep, RTO);
        end
        nd++;
        pf = fail_cnt;
      end
      if (c == 114) begin
        n_chk++;
        if (locked !== 1'b1) begin
          n_fail++;
          $display("FAIL tmo_locked got %0d exp 1", locked);
        end
      end
      if (c == 115) begin
        n_chk++;
        if (got_v !== 19'd0) begin
          n_fail++;
          $display("FAIL tmo_rst_lock got %h exp 0", got_v);
        end
      end
    end
    rst = 1'b0;
    n_chk++;
    if (nd != 3) begin
      n_fail++;
      $display("FAIL tmo_rounds got %0d exp 3", nd);
    end
  endtask

  task automatic test_entry_timeout();
    int ends = 0;
    int at = -1;
    int exp_ends = TO_EN ? 1 : 0;
    int exp_at = TO_EN ? (7 + ETO) : -1;
    int exp_st = TO_EN ? 0 : 1;
    test_reset();
    for (int c = 0; c < 75; c++) begin
      btn_start_n = !(c < 6);
      sw = 10'($urandom);
      @(posedge clk); #1;
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL eto_model cyc %0d got %h exp %h", c, got_v, exp_v);
      end
      if (end_pulse) begin
        ends++;
        if (at < 0) at = c + 1;
      end
    end
    n_chk++;
    if (ends != exp_ends || at != exp_at) begin
      n_fail++;
      $display("FAIL eto_end got %0d at %0d exp %0d at %0d",
               ends, at, exp_ends, exp_at);
    end
    n_chk++;
    if (int'(seq_state) != exp_st) begin
      n_fail++;
      $display("FAIL eto_state got %0d exp %0d", seq_state, exp_st);
    end
  endtask

  task automatic test_same_cycle();
    int sp = 0;
    int ep = 0;
    test_reset();
    for (int c = 0; c < 40; c++) begin
      btn_end_n = !(c < 6 || (c >= 15 && c < 21));
      btn_start_n = !(c >= 15 && c < 21);
      @(posedge clk); #1;
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL same_model cyc %0d got %h exp %h", c, got_v, exp_v);
      end
      if (start_pulse) sp++;
      if (end_pulse) ep++;
      if (c == 12) begin
        n_chk++;
        if (seq_state !== 2'd0) begin
          n_fail++;
          $display("FAIL idle_end_ignored got %0d exp 0", seq_state);
        end
      end
    end
    n_chk++;
    if (sp != 1 || ep != 0 || seq_state !== 2'd1) begin
      n_fail++;
      $display("FAIL same_cycle got s%0d e%0d st%0d exp s1 e0 st1",
               sp, ep, seq_state);
    end
  endtask

  task automatic test_random();
    int h0 = 0;
    int h1 = 0;
    int sp = 0;
    test_reset();
    for (int c = 0; c < 3000; c++) begin
      if (h0 == 0) begin
        btn_start_n = 1'($urandom);
        h0 = $urandom_range(1, 12);
      end
      if (h1 == 0) begin
        btn_end_n = 1'($urandom);
        h1 = $urandom_range(1, 12);
      end
      h0--;
      h1--;
      sw = 10'($urandom);
      chk_done = ($urandom_range(0, 5) == 0);
      chk_pass = 1'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      @(posedge clk); #1;
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL rand_model cyc %0d got %h exp %h", c, got_v, exp_v);
      end
      if (start_pulse) sp++;
    end
    rst = 1'b0;
    n_chk++;
    if (sp == 0) begin
      n_fail++;
      $display("FAIL rand_activity got 0 start pulses exp >0");
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    btn_start_n = 1'b1;
    btn_end_n = 1'b1;
    sw = '0;
    chk_done = 1'b0;
    chk_pass = 1'b0;
    test_reset();
    test_start_press();
    test_bounce();
    test_pass_round();
    test_lockout();
    test_timeout();
    test_entry_timeout();
    test_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
